clk_div_multi: RTL and testbench

- Parametrised successor to the board clock divider.
- Keeps a free-running divide counter bus for debug and LED blinkers.
- Adds NCH independent, runtime-programmable divided clocks, each with a one-cycle tick strobe.
- Channel 0 has a single-step mode for manual CPU clocking; divisor changes take effect only at period boundaries, so no runt pulses are emitted.

---
 rtl/clk_div_multi.sv | 184 ++++++++++++++++++
 tb/tb_clk_div_multi.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: free-running debug counter plus NCH runtime-programmable
// 50%-duty clock dividers, each with a one-cycle tick on its rising edge.
// Channel 0 can be parked low and single-stepped one full period at a time.
// Divisor writes are held pending and take effect only at a falling boundary,
// so a period already in progress always completes and no runt pulses appear.
module clk_div_multi #(
   parameter int CNT_W = 32,
   parameter int NCH   = 2,
   parameter int DIV_W = 16,
   parameter int CH_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_wr,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ack,
   input  logic             step_mode,
   input  logic             step_req,
   output logic [CNT_W-1:0] clkdiv,
   output logic [NCH-1:0]   clk_out,
   output logic [NCH-1:0]   tick
);

   typedef enum logic [1:0] {ST_RUN, ST_IDLE, ST_STEP} ch0_state_t;

   logic [NCH-1:0][DIV_W-1:0] div_q;
   logic [NCH-1:0][DIV_W-1:0] cnt_q;
   logic [NCH-1:0][DIV_W-1:0] pend_div_q;
   logic [NCH-1:0][DIV_W-1:0] cnt_nxt;
   logic [NCH-1:0]            pend_q;
   logic [NCH-1:0]            out_nxt;
   logic [NCH-1:0]            tick_nxt;
   logic [NCH-1:0]            at_lim;
   logic [NCH-1:0]            apply;
   logic [NCH-1:0]            wr_hit;

   ch0_state_t       state_q;
   ch0_state_t       state_nxt;
   logic             step_q;
   logic             step_rise;
   logic [DIV_W-1:0] ch0_cnt_nxt;
   logic             ch0_out_nxt;
   logic             ch0_tick_nxt;
   logic             ch0_apply;

   assign step_rise = step_req & ~step_q;

   // Free-running debug counter; wraps silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clkdiv <= '0;
      end else begin
         // NOTE: state is updated with <= so every register samples pre-edge values.
         clkdiv <= clkdiv + CNT_W'(1);
      end
   end

   // Step-request edge register and write acknowledge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q  <= 1'b0;
         cfg_ack <= 1'b0;
      end else begin
         step_q  <= step_req;
         cfg_ack <= |wr_hit;
      end
   end

   // Per-channel terminal-count and write-select decode.
   always_comb begin
      // NOTE: defaults first, so no path through this block can infer a latch.
      at_lim = '0;
      wr_hit = '0;
      for (int i = 0; i < NCH; i++) begin
         at_lim[i] = (cnt_q[i] == div_q[i]);
         wr_hit[i] = cfg_wr && (cfg_ch == CH_W'(i));
      end
   end

   // Channel 0 state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_nxt;
   end

   // Channel 0 next state: park at a falling boundary, step on a request edge.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_RUN:  if (at_lim[0] && clk_out[0] && step_mode) state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (!step_mode)     state_nxt = ST_RUN;
            else if (step_rise) state_nxt = ST_STEP;
         end
         ST_STEP: if (at_lim[0] && !clk_out[0]) state_nxt = ST_IDLE;
         default: state_nxt = ST_RUN;
      endcase
   end

   // Channel 0 outputs: counter/clock next values and divisor apply point.
   always_comb begin
      ch0_cnt_nxt  = cnt_q[0];
      ch0_out_nxt  = clk_out[0];
      ch0_tick_nxt = 1'b0;
      ch0_apply    = 1'b0;
      case (state_q)
         ST_RUN, ST_STEP: begin
            if (at_lim[0]) begin
               ch0_cnt_nxt  = '0;
               // A step ends low instead of starting another high phase.
               ch0_out_nxt  = (state_q == ST_RUN) ? ~clk_out[0] : 1'b0;
               ch0_tick_nxt = (state_q == ST_RUN) && !clk_out[0];
               ch0_apply    = clk_out[0] & pend_q[0];
            end else begin
               ch0_cnt_nxt  = cnt_q[0] + DIV_W'(1);
            end
         end
         ST_IDLE: begin
            // Parked: counter held at 0 and a pending divisor applies at once.
            ch0_cnt_nxt = '0;
            ch0_apply   = pend_q[0];
            if (step_mode && step_rise) begin
               ch0_out_nxt  = 1'b1;
               ch0_tick_nxt = 1'b1;
            end else begin
               ch0_out_nxt  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Free-running channels 1..NCH-1, with channel 0 taken from its FSM.
   always_comb begin
      cnt_nxt  = cnt_q;
      out_nxt  = clk_out;
      tick_nxt = '0;
      apply    = '0;
      cnt_nxt[0]  = ch0_cnt_nxt;
      out_nxt[0]  = ch0_out_nxt;
      tick_nxt[0] = ch0_tick_nxt;
      apply[0]    = ch0_apply;
      for (int i = 1; i < NCH; i++) begin
         if (at_lim[i]) begin
            cnt_nxt[i]  = '0;
            out_nxt[i]  = ~clk_out[i];
            tick_nxt[i] = ~clk_out[i];
         end else begin
            cnt_nxt[i]  = cnt_q[i] + DIV_W'(1);
         end
         apply[i] = at_lim[i] & clk_out[i] & pend_q[i];
      end
   end

   // Channel registers: counters, clocks, ticks, active and pending divisors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: divisors and pending writes are reset too; a reset must drop
         // every programmed divisor, not only the counters.
         cnt_q      <= '0;
         div_q      <= '0;
         pend_div_q <= '0;
         pend_q     <= '0;
         clk_out    <= '0;
         tick       <= '0;
      end else begin
         cnt_q   <= cnt_nxt;
         clk_out <= out_nxt;
         tick    <= tick_nxt;
         for (int i = 0; i < NCH; i++) begin
            if (apply[i]) div_q[i] <= pend_div_q[i];
            // A write landing on an apply boundary stays pending for the next one.
            if (wr_hit[i]) begin
               pend_div_q[i] <= cfg_div;
               pend_q[i]     <= 1'b1;
            end else if (apply[i]) begin
               pend_q[i]     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi. Expected waveforms are written per cycle
// from the intended behaviour, pushed to a scoreboard just before each clock
// edge and popped/compared one step after it.
module tb_clk_div_multi;

   localparam int CNT_W = 8;
   localparam int NCH   = 2;
   localparam int DIV_W = 16;
   localparam int CH_W  = 3;

   typedef enum int {K_CNT, K_OUT, K_TICK, K_ACK} kind_t;
   typedef struct {
      int          cyc;
      kind_t       kind;
      logic [31:0] val;
      string       tag;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cfg_wr;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_ack;
   logic             step_mode;
   logic             step_req;
   logic [CNT_W-1:0] clkdiv;
   logic [NCH-1:0]   clk_out;
   logic [NCH-1:0]   tick;

   int   vectors     = 0;
   int   miscompares = 0;
   int   n           = 0;
   int   phase       = 0;
   exp_t sb[$];

   clk_div_multi #(
      .CNT_W(CNT_W),
      .NCH  (NCH),
      .DIV_W(DIV_W),
      .CH_W (CH_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_wr   (cfg_wr),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_ack  (cfg_ack),
      .step_mode(step_mode),
      .step_req (step_req),
      .clkdiv   (clkdiv),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   // Phase 0 timeline: ch1 div 0 -> 3 (applied at 22), ch0 div 0 -> 2
   // (applied at 48) -> 1 (applied at 84, parked), steps at 89 and 101,
   // free run again from 109. Phase 1: both channels at div 0 after reset.
   function automatic logic [1:0] exp_out(int c);
      logic o0, o1;
      if (phase != 0) return {2{c % 2 == 1}};
      if (c < 48)                         o0 = (c % 2 == 1);
      else if (c <= 84)                   o0 = ((c - 48) % 6 >= 3);
      else if (c == 89 || c == 90 || c == 101 || c == 102) o0 = 1'b1;
      else if (c >= 109)                  o0 = ((c - 109) % 4 >= 2);
      else                                o0 = 1'b0;
      if (c < 22) o1 = (c % 2 == 1);
      else        o1 = ((c - 22) % 8 >= 4);
      return {o1, o0};
   endfunction

   function automatic logic [1:0] exp_tick(int c);
      logic t0, t1;
      if (phase != 0) return {2{c % 2 == 1}};
      if (c < 48)                 t0 = (c % 2 == 1);
      else if (c <= 84)           t0 = ((c - 48) % 6 == 3);
      else if (c == 89 || c == 101) t0 = 1'b1;
      else if (c >= 109)          t0 = ((c - 109) % 4 == 2);
      else                        t0 = 1'b0;
      if (c < 22) t1 = (c % 2 == 1);
      else        t1 = ((c - 22) % 8 == 4);
      return {t1, t0};
   endfunction

   function automatic logic exp_ack(int c);
      if (phase != 0) return 1'b0;
      return (c == 21 || c == 46 || c == 47 || c == 81);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " clkdiv"},  32'(clkdiv),  32'd0);
      check({tag, " clk_out"}, 32'(clk_out), 32'd0);
      check({tag, " tick"},    32'(tick),    32'd0);
      check({tag, " cfg_ack"}, 32'(cfg_ack), 32'd0);
   endtask

   task automatic push_expect(input int c);
      exp_t e;
      e.cyc  = c;
      e.kind = K_CNT;
      e.val  = 32'(c % (1 << CNT_W));
      e.tag  = $sformatf("p%0d c%0d clkdiv", phase, c);
      sb.push_back(e);
      e.kind = K_OUT;
      e.val  = 32'(exp_out(c));
      e.tag  = $sformatf("p%0d c%0d clk_out", phase, c);
      sb.push_back(e);
      e.kind = K_TICK;
      e.val  = 32'(exp_tick(c));
      e.tag  = $sformatf("p%0d c%0d tick", phase, c);
      sb.push_back(e);
      e.kind = K_ACK;
      e.val  = 32'(exp_ack(c));
      e.tag  = $sformatf("p%0d c%0d cfg_ack", phase, c);
      sb.push_back(e);
   endtask

   // One clock: queue the expectation for the coming edge, then compare.
   task automatic cyc();
      exp_t        e;
      logic [31:0] obs;
      push_expect(n + 1);
      @(posedge clk);
      #1;
      n++;
      while (sb.size() > 0 && sb[0].cyc <= n) begin
         e = sb.pop_front();
         case (e.kind)
            K_CNT:   obs = 32'(clkdiv);
            K_OUT:   obs = 32'(clk_out);
            K_TICK:  obs = 32'(tick);
            default: obs = 32'(cfg_ack);
         endcase
         check(e.tag, obs, e.val);
      end
   endtask

   task automatic run_to(input int target);
      while (n < target) cyc();
   endtask

   initial begin
      rst_n     = 1'b0;
      cfg_wr    = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      step_mode = 1'b0;
      step_req  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("in reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_idle("released");

      // Both channels at div 0: clk/2 with a tick every other cycle.
      run_to(20);

      // ch1 div=3 written while clk_out[1] is low; applies at the next fall.
      cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd3;
      cyc();
      cfg_wr = 1'b0;
      run_to(45);

      // ch0 div=5 then div=2 before its next falling boundary: only 2 applies.
      cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd5;
      cyc();
      cfg_div = 16'd2;
      cyc();
      cfg_wr = 1'b0;
      run_to(70);

      // Out-of-range channels are ignored.
      cfg_wr = 1'b1; cfg_ch = 3'd7; cfg_div = 16'd1;
      cyc();
      cfg_wr = 1'b0;
      run_to(74);
      cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd1;
      cyc();
      cfg_wr = 1'b0;
      run_to(80);

      // ch0 div=1, then single-step mode.
      cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd1;
      cyc();
      cfg_wr = 1'b0;
      run_to(82);
      step_mode = 1'b1;
      run_to(88);
      step_req = 1'b1;
      cyc();
      step_req = 1'b0;
      cyc();
      step_req = 1'b1;       // edge inside the step: must be ignored
      run_to(94);
      step_req = 1'b0;
      run_to(100);
      step_req = 1'b1;       // second step
      run_to(106);
      step_req = 1'b0;
      run_to(108);
      step_mode = 1'b0;      // back to free run
      run_to(123);

      // Asynchronous reset in the middle of a ch1 high phase.
      #2 rst_n = 1'b0;
      #1 check_idle("async reset");
      repeat (2) @(posedge clk);
      #1 check_idle("reset held");
      @(negedge clk);
      phase = 1;
      n     = 0;
      rst_n = 1'b1;
      #1 check_idle("re-released");
      // Divisors were lost; run long enough to see clkdiv wrap.
      run_to(262);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
